// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants
// and the coordinate type shared by the sync generator.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int HD  = 640;
  localparam int HFP = 16;
  localparam int HSW = 96;
  localparam int HBP = 48;

  localparam int VD  = 480;
  localparam int VFP = 10;
  localparam int VSW = 2;
  localparam int VBP = 33;

  localparam int H_TOTAL = HD + HFP + HSW + HBP;
  localparam int V_TOTAL = VD + VFP + VSW + VBP;

  function automatic logic in_range(
    input coord_t v,
    input coord_t lo,
    input coord_t hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from the sync generator
// to the monitor pins and the pixel pipeline.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   p_tick;
  coord_t pixel_x;
  coord_t pixel_y;

  modport master (
    output hsync,
    output vsync,
    output video_on,
    output p_tick,
    output pixel_x,
    output pixel_y
  );

  modport slave (
    input hsync,
    input vsync,
    input video_on,
    input p_tick,
    input pixel_x,
    input pixel_y
  );

endinterface

// File: rtl/pixel_tick_div.sv
// Mod-DIV counter; p_tick marks the last clock
// of every DIV-clock pixel period.
module pixel_tick_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign p_tick = (cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-rate enable, h/v position
// counters, registered active-low syncs, visible flag.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int DIV = 2,
  parameter int HD  = vga_timing_pkg::HD,
  parameter int HFP = vga_timing_pkg::HFP,
  parameter int HSW = vga_timing_pkg::HSW,
  parameter int HBP = vga_timing_pkg::HBP,
  parameter int VD  = vga_timing_pkg::VD,
  parameter int VFP = vga_timing_pkg::VFP,
  parameter int VSW = vga_timing_pkg::VSW,
  parameter int VBP = vga_timing_pkg::VBP
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = HD + HFP + HSW + HBP;
  localparam int V_TOTAL = VD + VFP + VSW + VBP;

  localparam coord_t H_VIS   = coord_t'(HD);
  localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t HS_FROM = coord_t'(HD + HFP);
  localparam coord_t HS_TO   = coord_t'(HD + HFP + HSW - 1);

  localparam coord_t V_VIS   = coord_t'(VD);
  localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
  localparam coord_t VS_FROM = coord_t'(VD + VFP);
  localparam coord_t VS_TO   = coord_t'(VD + VFP + VSW - 1);

  logic   p_tick;
  coord_t h_cnt;
  coord_t v_cnt;
  coord_t h_next;
  coord_t v_next;
  logic   hsync_q;
  logic   vsync_q;
  logic   h_end;
  logic   v_end;

  pixel_tick_div #(
    .DIV (DIV)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  assign h_end = (h_cnt == H_LAST);
  assign v_end = (v_cnt == V_LAST);

  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (p_tick) begin
      if (h_end) begin
        h_next = '0;
        v_next = v_end ? '0 : v_cnt + coord_t'(1);
      end else begin
        h_next = h_cnt + coord_t'(1);
      end
    end
  end

  // Syncs decode the next count so they change on the
  // same edge as the counters and never lag pixel_x.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      h_cnt   <= h_next;
      v_cnt   <= v_next;
      hsync_q <= ~in_range(h_next, HS_FROM, HS_TO);
      vsync_q <= ~in_range(v_next, VS_FROM, VS_TO);
    end
  end

  assign vga.p_tick   = p_tick;
  assign vga.pixel_x  = h_cnt;
  assign vga.pixel_y  = v_cnt;
  assign vga.hsync    = hsync_q;
  assign vga.vsync    = vsync_q;
  assign vga.video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size timing for lines, a shrunken
// raster for vertical and frame behaviour.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if va ();
  vga_sync_gen_if vb ();

  vga_sync_gen dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (va)
  );

  // Small raster: H_TOTAL=15 (hsync x 10..12),
  // V_TOTAL=11 (vsync y 6..7), frame = 330 clocks.
  vga_sync_gen #(
    .DIV (2),
    .HD  (8),
    .HFP (2),
    .HSW (3),
    .HBP (2),
    .VD  (4),
    .VFP (2),
    .VSW (2),
    .VBP (3)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (vb)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
  endtask

  task automatic reset_b();
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    steps(2);
    checks++;
    if (va.pixel_x !== 10'd0 || va.pixel_y !== 10'd0 ||
        va.hsync !== 1'b1 || va.vsync !== 1'b1 ||
        va.video_on !== 1'b1 || va.p_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b want 0 0 1 1 1 0",
               va.pixel_x, va.pixel_y, va.hsync, va.vsync,
               va.video_on, va.p_tick);
    end
    steps(3);
    checks++;
    if (va.p_tick !== 1'b0 || va.pixel_x !== 10'd0) begin
      failures++;
      $display("FAIL reset_hold: pt=%b x=%0d want pt=0 x=0",
               va.p_tick, va.pixel_x);
    end
    rst_a = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step();
      checks++;
      if (va.p_tick !== 1'(n % 2) || va.pixel_x !== 10'(n / 2)) begin
        failures++;
        $display("FAIL tick_start clk%0d: pt=%b x=%0d want pt=%0d x=%0d",
                 n, va.p_tick, va.pixel_x, n % 2, n / 2);
      end
    end
  endtask

  task automatic test_hsweep();
    int bad = 0;
    int bad_n = -1;
    int lows = 0;
    int fall_x = -1;
    logic prev_vo = 1'b1;
    reset_a();
    for (int n = 1; n <= 1600; n++) begin
      int t, ex, ey;
      logic ehs, evo;
      step();
      t = n / 2;
      ex = t % 800;
      ey = t / 800;
      ehs = !(ex >= 656 && ex <= 751);
      evo = (ex < 640) && (ey < 480);
      if (va.pixel_x !== 10'(ex) || va.pixel_y !== 10'(ey) ||
          va.p_tick !== 1'(n % 2) || va.hsync !== ehs ||
          va.video_on !== evo) begin
        bad++;
        if (bad_n < 0) bad_n = n;
      end
      if (va.hsync === 1'b0) lows++;
      if (prev_vo && va.video_on === 1'b0 && fall_x < 0)
        fall_x = int'(va.pixel_x);
      prev_vo = va.video_on;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hsweep_track: %0d bad clocks (first clk %0d) want 0",
               bad, bad_n);
    end
    checks++;
    if (lows !== 192) begin
      failures++;
      $display("FAIL hsync_low_clks: got %0d want 192", lows);
    end
    checks++;
    if (fall_x !== 640) begin
      failures++;
      $display("FAIL video_on_fall_x: got %0d want 640", fall_x);
    end
  endtask

  task automatic test_line_wrap();
    int cnt = 0;
    int prev_x;
    reset_a();
    steps(1599);
    checks++;
    if (va.pixel_x !== 10'd799 || va.pixel_y !== 10'd0 ||
        va.p_tick !== 1'b1) begin
      failures++;
      $display("FAIL line_end: x=%0d y=%0d pt=%b want 799 0 1",
               va.pixel_x, va.pixel_y, va.p_tick);
    end
    step();
    checks++;
    if (va.pixel_x !== 10'd0 || va.pixel_y !== 10'd1) begin
      failures++;
      $display("FAIL line_wrap: x=%0d y=%0d want 0 1",
               va.pixel_x, va.pixel_y);
    end
    prev_x = int'(va.pixel_x);
    do begin
      step();
      cnt++;
      if (va.pixel_x === 10'd0 && prev_x != 0) break;
      prev_x = int'(va.pixel_x);
    end while (cnt < 2000);
    checks++;
    if (cnt !== 1600) begin
      failures++;
      $display("FAIL line_period: got %0d clocks want 1600", cnt);
    end
  endtask

  task automatic test_vertical();
    int bad = 0;
    int bad_n = -1;
    int vlow = 0;
    int vo_bottom = 0;
    reset_b();
    for (int n = 1; n <= 660; n++) begin
      int t, ex, ey;
      logic ehs, evs, evo;
      step();
      t = n / 2;
      ex = t % 15;
      ey = (t / 15) % 11;
      ehs = !(ex >= 10 && ex <= 12);
      evs = !(ey >= 6 && ey <= 7);
      evo = (ex < 8) && (ey < 4);
      if (vb.pixel_x !== 10'(ex) || vb.pixel_y !== 10'(ey) ||
          vb.hsync !== ehs || vb.vsync !== evs ||
          vb.video_on !== evo) begin
        bad++;
        if (bad_n < 0) bad_n = n;
      end
      if (vb.vsync === 1'b0) vlow++;
      if (vb.video_on === 1'b1 && vb.pixel_y >= 10'd4) vo_bottom++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL vsweep_track: %0d bad clocks (first clk %0d) want 0",
               bad, bad_n);
    end
    checks++;
    if (vlow !== 120) begin
      failures++;
      $display("FAIL vsync_low_clks: got %0d want 120", vlow);
    end
    checks++;
    if (vo_bottom !== 0) begin
      failures++;
      $display("FAIL video_on_blank_rows: got %0d want 0", vo_bottom);
    end
  endtask

  task automatic test_frame_wrap();
    int cnt = 0;
    logic prev_org;
    reset_b();
    steps(329);
    checks++;
    if (vb.pixel_x !== 10'd14 || vb.pixel_y !== 10'd10 ||
        vb.p_tick !== 1'b1) begin
      failures++;
      $display("FAIL frame_end: x=%0d y=%0d pt=%b want 14 10 1",
               vb.pixel_x, vb.pixel_y, vb.p_tick);
    end
    step();
    checks++;
    if (vb.pixel_x !== 10'd0 || vb.pixel_y !== 10'd0 ||
        vb.hsync !== 1'b1 || vb.vsync !== 1'b1) begin
      failures++;
      $display("FAIL frame_wrap: x=%0d y=%0d hs=%b vs=%b want 0 0 1 1",
               vb.pixel_x, vb.pixel_y, vb.hsync, vb.vsync);
    end
    prev_org = 1'b1;
    do begin
      logic org;
      step();
      cnt++;
      org = (vb.pixel_x === 10'd0) && (vb.pixel_y === 10'd0);
      if (org && !prev_org) break;
      prev_org = org;
    end while (cnt < 1000);
    checks++;
    if (cnt !== 330) begin
      failures++;
      $display("FAIL frame_period: got %0d clocks want 330", cnt);
    end
  endtask

  task automatic test_mid_reset();
    reset_b();
    steps(203);
    checks++;
    if (vb.pixel_x !== 10'd11 || vb.pixel_y !== 10'd6 ||
        vb.hsync !== 1'b0 || vb.vsync !== 1'b0 ||
        vb.p_tick !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: x=%0d y=%0d hs=%b vs=%b pt=%b want 11 6 0 0 1",
               vb.pixel_x, vb.pixel_y, vb.hsync, vb.vsync, vb.p_tick);
    end
    rst_b = 1'b1;
    step();
    checks++;
    if (vb.pixel_x !== 10'd0 || vb.pixel_y !== 10'd0 ||
        vb.hsync !== 1'b1 || vb.vsync !== 1'b1 ||
        vb.p_tick !== 1'b0 || vb.video_on !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_small: x=%0d y=%0d hs=%b vs=%b pt=%b vo=%b want 0 0 1 1 0 1",
               vb.pixel_x, vb.pixel_y, vb.hsync, vb.vsync,
               vb.p_tick, vb.video_on);
    end
    rst_b = 1'b0;
    step();
    checks++;
    if (vb.p_tick !== 1'b1 || vb.pixel_x !== 10'd0) begin
      failures++;
      $display("FAIL mid_restart1: pt=%b x=%0d want 1 0",
               vb.p_tick, vb.pixel_x);
    end
    step();
    checks++;
    if (vb.p_tick !== 1'b0 || vb.pixel_x !== 10'd1) begin
      failures++;
      $display("FAIL mid_restart2: pt=%b x=%0d want 0 1",
               vb.p_tick, vb.pixel_x);
    end
    reset_a();
    steps(601);
    checks++;
    if (va.pixel_x !== 10'd300 || va.p_tick !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre_full: x=%0d pt=%b want 300 1",
               va.pixel_x, va.p_tick);
    end
    rst_a = 1'b1;
    step();
    checks++;
    if (va.pixel_x !== 10'd0 || va.pixel_y !== 10'd0 ||
        va.hsync !== 1'b1 || va.vsync !== 1'b1 ||
        va.p_tick !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_full: x=%0d y=%0d hs=%b vs=%b pt=%b want 0 0 1 1 0",
               va.pixel_x, va.pixel_y, va.hsync, va.vsync, va.p_tick);
    end
    rst_a = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_hsweep();
    test_line_wrap();
    test_vertical();
    test_frame_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
